zynq_axi_burst_initiator: RTL

ZYNQ_AXI_BURST_INITIATOR -- requirements
Module: zynq_axi_burst_initiator

---
 rtl/zynq_axi_burst_initiator_pkg.sv | 12 +
 rtl/zynq_axi_init_watchdog.sv | 15 +
 rtl/zynq_axi_burst_initiator.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/zynq_axi_burst_initiator_pkg.sv
// zynq_axi_burst_initiator_pkg: FSM state, AXI burst/response encodings and counter sizing shared by the initiator.
package zynq_axi_burst_initiator_pkg;
  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WDATA, WRESP, DONE} state_e;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam int BEAT_W = 4;
  function automatic logic [2:0] axi_size(input int data_width);
    return 3'($clog2(data_width / 8));
  endfunction
endpackage

// File: rtl/zynq_axi_init_watchdog.sv
// zynq_axi_init_watchdog: 16-bit stall counter; fires on the cycle the count reaches 0xFFFF.
module zynq_axi_init_watchdog (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic active_i,
  input  logic kick_i,
  output logic timeout_o
);
  logic [15:0] cnt_q, cnt_d;
  assign cnt_d = (!active_i || kick_i) ? 16'd0 : cnt_q + 16'd1;
  assign timeout_o = cnt_d == 16'hFFFF;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/zynq_axi_burst_initiator.sv
// zynq_axi_burst_initiator: single-outstanding AXI4 INCR burst master driven by a simple command/beat interface.
// Define ZYNQ_AXI_INIT_TIMEOUT_EN to add a stall watchdog that forces an erroring completion.
module zynq_axi_burst_initiator
  import zynq_axi_burst_initiator_pkg::*;
#(
  parameter int axi_addr_width_p = 32,
  parameter int axi_data_width_p = 64,
  parameter int axi_id_width_p   = 6,
  parameter int axi_burst_len_p  = 8
) (
  input  logic                          m00_axi_aclk,
  input  logic                          m00_axi_aresetn,
  input  logic                          cmd_v_i,
  output logic                          cmd_ready_o,
  input  logic                          cmd_w_i,
  input  logic [axi_addr_width_p-1:0]   cmd_addr_i,
  input  logic                          wdata_v_i,
  output logic                          wdata_ready_o,
  input  logic [axi_data_width_p-1:0]   wdata_i,
  output logic                          rdata_v_o,
  input  logic                          rdata_yumi_i,
  output logic [axi_data_width_p-1:0]   rdata_o,
  output logic                          done_v_o,
  output logic                          err_o,
  output logic [axi_id_width_p-1:0]     m00_axi_awid_o,
  output logic [axi_addr_width_p-1:0]   m00_axi_awaddr_o,
  output logic [3:0]                    m00_axi_awlen_o,
  output logic [2:0]                    m00_axi_awsize_o,
  output logic [1:0]                    m00_axi_awburst_o,
  output logic                          m00_axi_awlock_o,
  output logic [3:0]                    m00_axi_awcache_o,
  output logic [2:0]                    m00_axi_awprot_o,
  output logic [3:0]                    m00_axi_awqos_o,
  output logic                          m00_axi_awvalid_o,
  input  logic                          m00_axi_awready_i,
  output logic [axi_data_width_p-1:0]   m00_axi_wdata_o,
  output logic [axi_data_width_p/8-1:0] m00_axi_wstrb_o,
  output logic                          m00_axi_wlast_o,
  output logic                          m00_axi_wvalid_o,
  input  logic                          m00_axi_wready_i,
  input  logic [axi_id_width_p-1:0]     m00_axi_bid_i,
  input  logic [1:0]                    m00_axi_bresp_i,
  input  logic                          m00_axi_bvalid_i,
  output logic                          m00_axi_bready_o,
  output logic [axi_id_width_p-1:0]     m00_axi_arid_o,
  output logic [axi_addr_width_p-1:0]   m00_axi_araddr_o,
  output logic [3:0]                    m00_axi_arlen_o,
  output logic [2:0]                    m00_axi_arsize_o,
  output logic [1:0]                    m00_axi_arburst_o,
  output logic                          m00_axi_arlock_o,
  output logic [3:0]                    m00_axi_arcache_o,
  output logic [2:0]                    m00_axi_arprot_o,
  output logic [3:0]                    m00_axi_arqos_o,
  output logic                          m00_axi_arvalid_o,
  input  logic                          m00_axi_arready_i,
  input  logic [axi_id_width_p-1:0]     m00_axi_rid_i,
  input  logic [axi_data_width_p-1:0]   m00_axi_rdata_i,
  input  logic [1:0]                    m00_axi_rresp_i,
  input  logic                          m00_axi_rlast_i,
  input  logic                          m00_axi_rvalid_i,
  output logic                          m00_axi_rready_o
);
  localparam logic [BEAT_W-1:0] last_beat = BEAT_W'(axi_burst_len_p - 1);
  state_e                      state_q;
  logic [axi_addr_width_p-1:0] addr_q;
  logic [BEAT_W-1:0]           beat_q;
  logic                        err_q;
  logic                        aw_hs, w_hs, b_hs, ar_hs, r_hs, at_last, timeout;
  logic                        unused_ids;
  assign unused_ids = ^{m00_axi_bid_i, m00_axi_rid_i};
  assign at_last = beat_q == last_beat;
  assign cmd_ready_o       = m00_axi_aresetn && state_q == IDLE;
  assign m00_axi_awid_o    = '0;
  assign m00_axi_awaddr_o  = addr_q;
  assign m00_axi_awlen_o   = last_beat;
  assign m00_axi_awsize_o  = axi_size(axi_data_width_p);
  assign m00_axi_awburst_o = BURST_INCR;
  assign m00_axi_awlock_o  = 1'b0;
  assign m00_axi_awcache_o = '0;
  assign m00_axi_awprot_o  = '0;
  assign m00_axi_awqos_o   = '0;
  assign m00_axi_awvalid_o = state_q == WADDR;
  assign m00_axi_wdata_o   = wdata_i;
  assign m00_axi_wstrb_o   = '1;
  assign m00_axi_wlast_o   = state_q == WDATA && at_last;
  assign m00_axi_wvalid_o  = state_q == WDATA && wdata_v_i;
  assign wdata_ready_o     = state_q == WDATA && m00_axi_wready_i;
  assign m00_axi_bready_o  = state_q == WRESP;
  assign m00_axi_arid_o    = '0;
  assign m00_axi_araddr_o  = addr_q;
  assign m00_axi_arlen_o   = last_beat;
  assign m00_axi_arsize_o  = axi_size(axi_data_width_p);
  assign m00_axi_arburst_o = BURST_INCR;
  assign m00_axi_arlock_o  = 1'b0;
  assign m00_axi_arcache_o = '0;
  assign m00_axi_arprot_o  = '0;
  assign m00_axi_arqos_o   = '0;
  assign m00_axi_arvalid_o = state_q == RADDR;
  assign m00_axi_rready_o  = state_q == RDATA && rdata_yumi_i;
  assign rdata_v_o         = state_q == RDATA && m00_axi_rvalid_i;
  assign rdata_o           = m00_axi_rdata_i;
  assign done_v_o          = state_q == DONE;
  assign err_o             = state_q == DONE && err_q;
  assign aw_hs = m00_axi_awvalid_o && m00_axi_awready_i;
  assign w_hs  = m00_axi_wvalid_o && m00_axi_wready_i;
  assign b_hs  = m00_axi_bready_o && m00_axi_bvalid_i;
  assign ar_hs = m00_axi_arvalid_o && m00_axi_arready_i;
  assign r_hs  = m00_axi_rready_o && m00_axi_rvalid_i;
`ifdef ZYNQ_AXI_INIT_TIMEOUT_EN
  zynq_axi_init_watchdog u_watchdog (
    .clk_i     (m00_axi_aclk),
    .rst_ni    (m00_axi_aresetn),
    .active_i  (state_q != IDLE && state_q != DONE),
    .kick_i    (aw_hs || w_hs || b_hs || ar_hs || r_hs),
    .timeout_o (timeout)
  );
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn)
    if (!m00_axi_aresetn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else if (timeout) begin
      state_q <= DONE;
      err_q   <= 1'b1;
    end else
      case (state_q)
        IDLE: if (cmd_v_i) begin
          addr_q  <= cmd_addr_i;
          beat_q  <= '0;
          err_q   <= 1'b0;
          state_q <= cmd_w_i ? WADDR : RADDR;
        end
        RADDR: if (ar_hs) state_q <= RDATA;
        // A misplaced or missing rlast is flagged, but only rlast ends the burst.
        RDATA: if (r_hs) begin
          err_q  <= err_q | (m00_axi_rresp_i != RESP_OKAY) | (m00_axi_rlast_i != at_last);
          beat_q <= m00_axi_rlast_i ? '0 : at_last ? beat_q : beat_q + 1'b1;
          if (m00_axi_rlast_i) state_q <= DONE;
        end
        WADDR: if (aw_hs) state_q <= WDATA;
        WDATA: if (w_hs) begin
          beat_q <= at_last ? '0 : beat_q + 1'b1;
          if (at_last) state_q <= WRESP;
        end
        WRESP: if (b_hs) begin
          err_q   <= m00_axi_bresp_i != RESP_OKAY;
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
endmodule
